// File: rtl/insn_encoder.sv
// RV32I instruction encoder: checks decoded fields, packs them into 32-bit words
// and streams them out through a small FIFO with auto-incrementing byte addresses.
module insn_encoder #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_WRAP  = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_format,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_err,
  output logic [7:0]  o_err_cnt,
  input  logic        i_clr_err
);

  localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] WRAP_MASK   = ADDR_WRAP - 32'd1;
  localparam logic [31:0] BASE_REGION = BASE_ADDR & ~WRAP_MASK;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [31:0]      r_mem_addr [FIFO_DEPTH];
  logic [31:0]      r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_addr;
  logic [31:0]      r_hold_addr;
  logic [31:0]      r_hold_data;
  logic             r_err;
  logic [7:0]       r_err_cnt;

  logic        w_fit12, w_fit13, w_fit21;
  logic        w_onehot, w_op_ok, w_imm_ok, w_legal;
  logic [31:0] w_insn;
  logic        w_full, w_xfer, w_push, w_pop, w_bad;

  assign w_fit12  = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fit13  = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_fit21  = (&i_imm[31:20]) | ~(|i_imm[31:20]);
  assign w_onehot = (i_format != 6'd0) && ((i_format & (i_format - 6'd1)) == 6'd0);

  // Non-one-hot formats fall to the default arm and are rejected there.
  always_comb begin
    w_op_ok  = 1'b0;
    w_imm_ok = 1'b0;
    w_insn   = 32'd0;
    case (i_format)
      6'b000001: begin
        w_op_ok  = (i_opcode == 7'b0110011);
        w_imm_ok = 1'b1;
        w_insn   = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      6'b000010: begin
        w_op_ok  = (i_opcode == 7'b0000011) || (i_opcode == 7'b0010011) ||
                   (i_opcode == 7'b1100111);
        w_imm_ok = w_fit12;
        w_insn   = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      6'b000100: begin
        w_op_ok  = (i_opcode == 7'b0100011);
        w_imm_ok = w_fit12;
        w_insn   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      6'b001000: begin
        w_op_ok  = (i_opcode == 7'b1100011);
        w_imm_ok = w_fit13 && !i_imm[0];
        w_insn   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
      end
      6'b010000: begin
        w_op_ok  = (i_opcode == 7'b0110111) || (i_opcode == 7'b0010111);
        w_imm_ok = (i_imm[11:0] == 12'd0);
        w_insn   = {i_imm[31:12], i_rd, i_opcode};
      end
      6'b100000: begin
        w_op_ok  = (i_opcode == 7'b1101111);
        w_imm_ok = w_fit21 && !i_imm[0];
        w_insn   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      default: begin
        w_op_ok  = 1'b0;
        w_imm_ok = 1'b0;
        w_insn   = 32'd0;
      end
    endcase
  end

  assign w_legal = w_onehot && w_op_ok && w_imm_ok;

  // A same-cycle pop does not free a slot, so readiness depends only on occupancy.
  assign w_full  = (r_count == FULL_CNT);
  assign w_xfer  = i_valid && !w_full;
  assign w_push  = w_xfer && w_legal;
  assign w_bad   = w_xfer && !w_legal;
  assign w_pop   = (r_count != '0) && i_wr_ready;

  assign o_ready    = !w_full || !i_rst_n;
  assign o_wr_valid = (r_count != '0);
  assign o_wr_addr  = o_wr_valid ? r_mem_addr[r_rd_ptr] : r_hold_addr;
  assign o_wr_data  = o_wr_valid ? r_mem_data[r_rd_ptr] : r_hold_data;
  assign o_err      = r_err;
  assign o_err_cnt  = r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_mem_addr[r_wr_ptr] <= r_addr;
      r_mem_data[r_wr_ptr] <= w_insn;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_addr      <= BASE_ADDR;
      r_hold_addr <= BASE_ADDR;
      r_hold_data <= 32'd0;
      r_err       <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_addr   <= BASE_REGION | ((r_addr + 32'd4) & WRAP_MASK);
      end
      // Remember the departing word so the outputs hold it once the FIFO empties.
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_hold_addr <= o_wr_addr;
        r_hold_data <= o_wr_data;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_clr_err) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end else if (w_bad) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Directed-vector bench for insn_encoder: encodings, legality, backpressure,
// error flag/counter, address wrap and reset with buffered words.
module tb_insn_encoder;

  typedef struct {
    string       name;
    logic [5:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          legal;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [5:0]  i_format = '0;
  logic [6:0]  i_opcode = '0;
  logic [4:0]  i_rd = '0;
  logic [4:0]  i_rs1 = '0;
  logic [4:0]  i_rs2 = '0;
  logic [2:0]  i_funct3 = '0;
  logic [6:0]  i_funct7 = '0;
  logic [31:0] i_imm = '0;
  logic        o_wr_valid;
  logic        i_wr_ready = 1'b1;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_err;
  logic [7:0]  o_err_cnt;
  logic        i_clr_err = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          errCntExp = 0;
  int          popCount = 0;
  logic [31:0] expAddr = 32'd0;
  logic [31:0] lastAddr = 32'd0;
  exp_t        expQ[$];
  exp_t        monE;
  vec_t        vecs[16];

  insn_encoder #(.FIFO_DEPTH(2), .BASE_ADDR(32'h0), .ADDR_WRAP(32'h1000)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_format(i_format), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_err(o_err), .o_err_cnt(o_err_cnt),
    .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t mkVec(input string name, input logic [5:0] fmt,
      input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit legal, input logic [31:0] expData);
    vec_t v;
    v.name = name; v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.legal = legal; v.expData = expData;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the transfer.
  task automatic applyStimulus(input vec_t v);
    int waitCycles = 0;
    i_format = v.fmt; i_opcode = v.op; i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2;
    i_funct3 = v.f3; i_funct7 = v.f7; i_imm = v.imm; i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && waitCycles < 50) begin
      @(negedge i_clk);
      waitCycles++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept_timeout: got ready=0 expected ready=1", v.name);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end else begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      if (v.legal) begin
        expQ.push_back('{addr: expAddr, data: v.expData});
        expAddr = (expAddr + 32'd4) & 32'h0000_0FFF;
      end else begin
        errCntExp = (errCntExp < 255) ? errCntExp + 1 : 255;
      end
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(posedge i_clk); #1;
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain_timeout: got %0d pending expected 0", name, expQ.size());
    end
  endtask

  task automatic resetDut();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("ready_during_reset", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    expQ.delete();
    expAddr = 32'd0;
    errCntExp = 0;
  endtask

  // Every word leaving the DUT is compared in order against the expected queue.
  always @(negedge i_clk) begin
    if (i_rst_n && o_wr_valid && i_wr_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got addr=0x%08h data=0x%08h expected none",
                 o_wr_addr, o_wr_data);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr_addr", o_wr_addr, monE.addr);
        checkOutput("wr_data", o_wr_data, monE.data);
      end
      lastAddr = o_wr_addr;
      popCount++;
    end
  end

  initial begin
    logic [31:0] holdAddr;
    logic [31:0] holdData;
    logic [31:0] kv;
    int          popBase;

    vecs[0]  = mkVec("add",      6'b000001, 7'b0110011, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0,        1, 32'h002081B3);
    vecs[1]  = mkVec("addi",     6'b000010, 7'b0010011, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1, 32'h00500093);
    vecs[2]  = mkVec("sw",       6'b000100, 7'b0100011, 5'd31, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        1, 32'h0020A423);
    vecs[3]  = mkVec("beq",      6'b001000, 7'b1100011, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1, 32'hFE208EE3);
    vecs[4]  = mkVec("b_odd",    6'b001000, 7'b1100011, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        0, 32'h0);
    vecs[5]  = mkVec("jal",      6'b100000, 7'b1101111, 5'd1,  5'd5, 5'd0, 3'd7, 7'h00, 32'd8,        1, 32'h008000EF);
    vecs[6]  = mkVec("fmt2hot",  6'b000011, 7'b0110011, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0,        0, 32'h0);
    vecs[7]  = mkVec("lui",      6'b010000, 7'b0110111, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1, 32'h123452B7);
    vecs[8]  = mkVec("i_badop",  6'b000010, 7'b0110011, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0,        0, 32'h0);
    vecs[9]  = mkVec("sub",      6'b000001, 7'b0110011, 5'd5,  5'd6, 5'd7, 3'd0, 7'h20, 32'h0,        1, 32'h407302B3);
    vecs[10] = mkVec("addi_min", 6'b000010, 7'b0010011, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 1, 32'h80000093);
    vecs[11] = mkVec("addi_big", 6'b000010, 7'b0010011, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 0, 32'h0);
    vecs[12] = mkVec("lui_low",  6'b010000, 7'b0110111, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 0, 32'h0);
    vecs[13] = mkVec("jal_min",  6'b100000, 7'b1101111, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 1, 32'h8000006F);
    vecs[14] = mkVec("jal_big",  6'b100000, 7'b1101111, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 0, 32'h0);
    vecs[15] = mkVec("lw",       6'b000010, 7'b0000011, 5'd6,  5'd7, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 1, 32'hFFF3A303);

    $display("[TB] reset values");
    @(posedge i_clk); #1;
    resetDut();
    checkOutput("rst_wr_valid", {31'd0, o_wr_valid}, 32'd0);
    checkOutput("rst_wr_addr", o_wr_addr, 32'h0);
    checkOutput("rst_wr_data", o_wr_data, 32'h0);
    checkOutput("rst_err", {31'd0, o_err}, 32'd0);
    checkOutput("rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);

    $display("[TB] vector table");
    i_wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_valid"}, {31'd0, o_wr_valid}, {31'd0, vecs[i].legal});
      checkOutput({vecs[i].name, "_err_cnt"}, {24'd0, o_err_cnt}, errCntExp);
      checkOutput({vecs[i].name, "_err"}, {31'd0, o_err}, (errCntExp != 0) ? 32'd1 : 32'd0);
    end
    waitDrain("table");
    @(posedge i_clk); #1;
    checkOutput("empty_hold_data", o_wr_data, 32'hFFF3A303);

    $display("[TB] clear error with simultaneous illegal push");
    i_clr_err = 1'b1;
    applyStimulus(vecs[4]);
    i_clr_err = 1'b0;
    errCntExp = 0;
    checkOutput("clr_err", {31'd0, o_err}, 32'd0);
    checkOutput("clr_err_cnt", {24'd0, o_err_cnt}, 32'd0);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 256; i++) applyStimulus(vecs[6]);
    checkOutput("sat_err_cnt", {24'd0, o_err_cnt}, 32'd255);
    checkOutput("sat_err", {31'd0, o_err}, 32'd1);
    i_clr_err = 1'b1;
    @(posedge i_clk); #1;
    i_clr_err = 1'b0;
    errCntExp = 0;
    checkOutput("clr2_err_cnt", {24'd0, o_err_cnt}, 32'd0);

    $display("[TB] backpressure");
    i_wr_ready = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    checkOutput("full_ready", {31'd0, o_ready}, 32'd0);
    holdAddr = expQ[0].addr;
    holdData = expQ[0].data;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("stall_valid", {31'd0, o_wr_valid}, 32'd1);
    checkOutput("stall_addr", o_wr_addr, holdAddr);
    checkOutput("stall_data", o_wr_data, holdData);
    checkOutput("stall_ready", {31'd0, o_ready}, 32'd0);
    i_wr_ready = 1'b1;
    applyStimulus(vecs[2]);
    waitDrain("backpressure");

    $display("[TB] address wrap");
    resetDut();
    popBase = popCount;
    for (int k = 0; k < 1024; k++) begin
      kv = k;
      applyStimulus(mkVec("wrap", 6'b000010, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00,
                          {21'd0, kv[10:0]}, 1, {1'b0, kv[10:0], 20'h00093}));
    end
    waitDrain("wrap1024");
    checkOutput("wrap_count", popCount - popBase, 32'd1024);
    checkOutput("word1024_addr", lastAddr, 32'h0000_0FFC);
    applyStimulus(vecs[7]);
    waitDrain("wrap1025");
    checkOutput("word1025_addr", lastAddr, 32'h0000_0000);

    $display("[TB] reset with buffered words");
    i_wr_ready = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    resetDut();
    checkOutput("rst2_valid", {31'd0, o_wr_valid}, 32'd0);
    checkOutput("rst2_addr", o_wr_addr, 32'h0);
    checkOutput("rst2_ready", {31'd0, o_ready}, 32'd1);
    i_wr_ready = 1'b1;
    applyStimulus(vecs[9]);
    checkOutput("post_rst_addr", o_wr_addr, 32'h0);
    waitDrain("post_reset");

    repeat (2) @(posedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
